// File: rtl/wc_tile_loader.sv
// Sliding-window tile loader feeding a Winograd core: 9-sample tiles with stride 5,
// where each tile reuses the newest 4 samples of the previous one.
module wc_win_slot #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst)    q <= '0;
    else if (en) q <= d;
endmodule

module wc_tile_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [9:0]  s_data,
  input  logic        s_first,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [89:0] m_tile,
  output logic        m_first
);
  localparam int W = 10;
  localparam int N = 9;
  localparam int S = 5;
  localparam int O = N - S;
  localparam logic [3:0] CNT_LAST = 4'(N - 1);
  localparam logic [3:0] CNT_OVL  = 4'(O);

  typedef enum logic {FILL, STEADY} st_t;

  st_t                   st, st_n;
  logic [3:0]            cnt, cnt_n;
  logic [N-1:0][W-1:0]   win;
  logic [N-1:0][W-1:0]   win_n;
  logic                  acc, row_start, done;

  assign s_ready = !m_valid || m_ready;
  assign acc     = s_valid && s_ready;

  // Slot 0 is the newest sample, slot N-1 the oldest; an accept shifts toward N-1.
  assign win_n = {win[N-2:0], s_data};

  for (genvar g = 0; g < N; g++) begin : g_slot
    wc_win_slot #(.W(W)) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (acc),
      .d   (win_n[g]),
      .q   (win[g])
    );
  end

  // cnt is 0 only out of reset, so it doubles as the implicit row-start marker.
  assign row_start = s_first || (cnt == 4'd0);

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    done  = 1'b0;
    if (acc) begin
      if (row_start) begin
        cnt_n = 4'd1;
        st_n  = FILL;
      end else if (cnt == CNT_LAST) begin
        cnt_n = CNT_OVL;
        st_n  = STEADY;
        done  = 1'b1;
      end else begin
        cnt_n = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st  <= FILL;
      cnt <= 4'd0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end

  // A tile only completes on an accept, which requires s_ready, so a held tile is never overwritten.
  // FILL is only ever entered at a row start, so a tile completing from FILL is the row's first.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_valid <= 1'b0;
      m_tile  <= '0;
      m_first <= 1'b0;
    end else if (done) begin
      m_valid <= 1'b1;
      m_tile  <= win_n;
      m_first <= (st == FILL);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed plus random checks of wc_tile_loader against a row-history reference model.
module tb_wc_tile_loader;
  logic        clk, rst;
  logic        s_valid, s_ready, s_first;
  logic [9:0]  s_data;
  logic        m_valid, m_ready, m_first;
  logic [89:0] m_tile;

  int n_chk, n_fail;

  // Model: samples of the current row, the last 9 kept; a tile completes at row
  // sample counts 9, 14, 19, ... and consists of the 9 most recent samples.
  bit          fresh;
  int          rowcnt;
  logic [9:0]  hist[$];
  logic        mv, mf;
  logic [89:0] mt;

  wc_tile_loader dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
    .m_valid(m_valid), .m_ready(m_ready), .m_tile(m_tile), .m_first(m_first)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkt(input string tag, input logic [89:0] got, input logic [89:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [89:0] pack_hist();
    logic [89:0] t = '0;
    foreach (hist[i]) t = {t[79:0], hist[i]};
    return t;
  endfunction

  task automatic model_reset();
    fresh = 1; rowcnt = 0; hist.delete();
    mv = 0; mf = 0; mt = '0;
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input bit sv, input int sd, input bit sf, input bit mr);
    logic srdy_e;
    bit   acc;
    s_valid = sv; s_data = 10'(sd); s_first = sf; m_ready = mr;
    #1;
    srdy_e = !mv || mr;
    chk1("s_ready", s_ready, srdy_e);
    @(posedge clk);
    acc = sv && srdy_e;
    if (acc) begin
      if (sf || fresh) begin rowcnt = 0; hist.delete(); fresh = 0; end
      hist.push_back(10'(sd));
      if (hist.size() > 9) void'(hist.pop_front());
      rowcnt++;
    end
    if (acc && rowcnt >= 9 && (rowcnt - 9) % 5 == 0) begin
      mv = 1; mt = pack_hist(); mf = (rowcnt == 9);
    end else if (mv && mr) begin
      mv = 0;
    end
    @(negedge clk);
    chk1("m_valid", m_valid, mv);
    if (mv) begin
      chkt("m_tile", m_tile, mt);
      chk1("m_first", m_first, mf);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk1("rst_m_valid", m_valid, 1'b0);
    chkt("rst_m_tile", m_tile, 90'd0);
    chk1("rst_m_first", m_first, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  int fill_v[9]   = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
  int stride_v[9] = '{-18, -16, -28, -11, 1, 2, 3, 4, 5};

  initial begin
    logic [89:0] fill_exp, stride_exp;
    int          pulses;
    fill_exp = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101;
    stride_exp = '0;
    foreach (stride_v[i]) stride_exp = {stride_exp[79:0], 10'(stride_v[i])};
    n_chk = 0; n_fail = 0;
    clk = 0; s_valid = 0; s_data = '0; s_first = 0; m_ready = 0;
    @(negedge clk);
    do_reset();

    // Fill: first tile one cycle after the 9th accept
    for (int i = 0; i < 9; i++) cyc(1, fill_v[i], i == 0, 1);
    chkt("fill_tile", m_tile, fill_exp);
    chk1("fill_first", m_first, 1'b1);

    // Stride: only the 5th further sample completes a tile
    for (int i = 1; i <= 5; i++) cyc(1, i, 0, 1);
    chk1("stride_valid", m_valid, 1'b1);
    chkt("stride_tile", m_tile, stride_exp);
    chk1("stride_first", m_first, 1'b0);

    // Backpressure: tile held, inputs stalled for 10 cycles
    for (int i = 0; i < 10; i++) cyc(1, 100 + i, 0, 0);
    chkt("bp_tile_hold", m_tile, stride_exp);
    for (int i = 0; i < 10; i++) cyc(1, 200 + i, 0, 1);

    // Row restart from STEADY
    for (int i = 0; i < 3; i++) cyc(1, 300 + i, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 400 + i, i == 0, 1);
    chk1("restart_first", m_first, 1'b1);
    cyc(0, 0, 0, 1);

    // Reset mid-fill, then a clean fill
    for (int i = 0; i < 6; i++) cyc(1, 500 + i, i == 0, 1);
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 600 + i, 0, 1);
    chk1("post_rst_first", m_first, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Back-to-back: continuous stream, one pulse per 5 cycles after the first tile
    pulses = 0;
    for (int i = 0; i < 34; i++) begin
      cyc(1, $urandom_range(0, 1023), i == 0, 1);
      if (i >= 9 && m_valid) pulses++;
    end
    chk1("b2b_pulses", pulses == 5, 1'b1);

    // Random traffic with occasional row starts and resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 400 == 399) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
